// File: rtl/clock_set_ctrl.sv
// Button-driven time-set controller: RUN -> set hour -> set minute -> commit load strobe.
// Optional seconds editing stage is built when SET_SECONDS_EN is defined.
module clock_set_ctrl #(
    parameter int unsigned HOLD_CYCLES    = 50_000_000,
    parameter int unsigned REPEAT_CYCLES  = 10_000_000,
    parameter int unsigned BLINK_CYCLES   = 25_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [6:0] cur_sec,
    input  logic [6:0] cur_min,
    input  logic [6:0] cur_hour,
    output logic       run_en,
    output logic       load,
    output logic [6:0] load_sec,
    output logic [6:0] load_min,
    output logic [6:0] load_hour,
    output logic [1:0] edit_field,
    output logic       blink_on,
    output logic [6:0] shadow_min,
    output logic [6:0] shadow_hour
);

    localparam logic [2:0] StRun     = 3'd0;
    localparam logic [2:0] StSetHour = 3'd1;
    localparam logic [2:0] StSetMin  = 3'd2;
    localparam logic [2:0] StCommit  = 3'd4;
`ifdef SET_SECONDS_EN
    localparam logic [2:0] StSetSec  = 3'd3;
`endif

    logic [2:0]  state_q, state_d;
    logic        mode_prev_q, inc_prev_q;
    logic        mode_press_q, inc_press_q;
    logic [6:0]  shadow_hour_q, shadow_min_q;
    logic [6:0]  load_hour_q, load_min_q;
    logic [31:0] hold_cnt_q, blink_cnt_q, idle_cnt_q;
    logic        hold_active_q, repeating_q, blink_q;
    logic        editing, repeat_fire, timeout_hit, inc_step, enter_commit;
`ifdef SET_SECONDS_EN
    logic [6:0]  shadow_sec_q, load_sec_q;
`endif

    function automatic logic [6:0] wrap_inc(input logic [6:0] v, input logic [6:0] max_v);
        // Out-of-range captures also wrap straight to zero.
        return (v >= max_v) ? 7'd0 : v + 7'd1;
    endfunction

    // Registered rising-edge detect on both buttons.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_prev_q  <= 1'b0;
            inc_prev_q   <= 1'b0;
            mode_press_q <= 1'b0;
            inc_press_q  <= 1'b0;
        end else begin
            mode_prev_q  <= btn_mode;
            inc_prev_q   <= btn_inc;
            mode_press_q <= btn_mode & ~mode_prev_q;
            inc_press_q  <= btn_inc & ~inc_prev_q;
        end
    end

    always_comb begin
        editing = (state_q == StSetHour) || (state_q == StSetMin);
`ifdef SET_SECONDS_EN
        if (state_q == StSetSec) begin
            editing = 1'b1;
        end
`endif
    end

    always_comb begin
        repeat_fire = 1'b0;
        if (editing && btn_inc && hold_active_q && !inc_press_q) begin
            if (repeating_q) begin
                repeat_fire = (hold_cnt_q == REPEAT_CYCLES - 1);
            end else begin
                repeat_fire = (hold_cnt_q == HOLD_CYCLES - 1);
            end
        end
    end

    assign timeout_hit = editing && !mode_press_q && !inc_press_q &&
                         (idle_cnt_q == TIMEOUT_CYCLES - 1);
    // Mode wins over a simultaneous increment.
    assign inc_step    = editing && !mode_press_q && (inc_press_q || repeat_fire);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun: begin
                if (mode_press_q) begin
                    state_d = StSetHour;
                end
            end
            StSetHour: begin
                if (mode_press_q) begin
                    state_d = StSetMin;
                end else if (timeout_hit) begin
                    state_d = StRun;
                end
            end
            StSetMin: begin
                if (mode_press_q) begin
`ifdef SET_SECONDS_EN
                    state_d = StSetSec;
`else
                    state_d = StCommit;
`endif
                end else if (timeout_hit) begin
                    state_d = StRun;
                end
            end
`ifdef SET_SECONDS_EN
            StSetSec: begin
                if (mode_press_q) begin
                    state_d = StCommit;
                end else if (timeout_hit) begin
                    state_d = StRun;
                end
            end
`endif
            StCommit: state_d = StRun;
            default:  state_d = StRun;
        endcase
    end

    assign enter_commit = (state_q != StCommit) && (state_d == StCommit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_hour_q <= 7'd0;
            shadow_min_q  <= 7'd0;
        end else if (state_q == StRun && mode_press_q) begin
            shadow_hour_q <= cur_hour;
            shadow_min_q  <= cur_min;
        end else if (inc_step) begin
            if (state_q == StSetHour) begin
                shadow_hour_q <= wrap_inc(shadow_hour_q, 7'd23);
            end else if (state_q == StSetMin) begin
                shadow_min_q <= wrap_inc(shadow_min_q, 7'd59);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_hour_q <= 7'd0;
            load_min_q  <= 7'd0;
        end else if (enter_commit) begin
            load_hour_q <= shadow_hour_q;
            load_min_q  <= shadow_min_q;
        end
    end

`ifdef SET_SECONDS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_sec_q <= 7'd0;
            load_sec_q   <= 7'd0;
        end else begin
            if (state_q == StRun && mode_press_q) begin
                shadow_sec_q <= cur_sec;
            end else if (inc_step && state_q == StSetSec) begin
                shadow_sec_q <= wrap_inc(shadow_sec_q, 7'd59);
            end
            if (enter_commit) begin
                load_sec_q <= shadow_sec_q;
            end
        end
    end
    assign load_sec = load_sec_q;
`else
    // Seconds are never edited in this build; the counter restarts each commit at :00.
    logic unused_cur_sec;
    assign unused_cur_sec = ^cur_sec;
    assign load_sec = 7'd0;
`endif

    // Hold counter: first phase waits HOLD_CYCLES, then repeats every REPEAT_CYCLES.
    always_ff @(posedge clk) begin
        if (rst || !editing || !btn_inc || mode_press_q) begin
            hold_cnt_q    <= 32'd0;
            hold_active_q <= 1'b0;
            repeating_q   <= 1'b0;
        end else if (inc_press_q) begin
            hold_cnt_q    <= 32'd1;
            hold_active_q <= 1'b1;
            repeating_q   <= 1'b0;
        end else if (hold_active_q) begin
            if (repeat_fire) begin
                hold_cnt_q  <= 32'd0;
                repeating_q <= 1'b1;
            end else begin
                hold_cnt_q <= hold_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !editing || mode_press_q || inc_press_q || timeout_hit) begin
            idle_cnt_q <= 32'd0;
        end else begin
            idle_cnt_q <= idle_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !editing) begin
            blink_cnt_q <= 32'd0;
            blink_q     <= 1'b1;
        end else if (blink_cnt_q == BLINK_CYCLES - 1) begin
            blink_cnt_q <= 32'd0;
            blink_q     <= ~blink_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 32'd1;
        end
    end

    always_comb begin
        edit_field = 2'd0;
        case (state_q)
            StSetHour: edit_field = 2'd1;
            StSetMin:  edit_field = 2'd2;
`ifdef SET_SECONDS_EN
            StSetSec:  edit_field = 2'd3;
`endif
            default:   edit_field = 2'd0;
        endcase
    end

    assign run_en      = (state_q == StRun);
    assign load        = (state_q == StCommit);
    assign load_hour   = load_hour_q;
    assign load_min    = load_min_q;
    assign blink_on    = blink_q;
    assign shadow_hour = shadow_hour_q;
    assign shadow_min  = shadow_min_q;

endmodule
